// File: rtl/pd_pkg.sv
// Shared types for the pulse measurement block.
// Mode/state encodings plus a helper that folds the reserved mode.
package pd_pkg;

  typedef enum logic [1:0] {
    PD_PERIOD,
    PD_HIGH,
    PD_LOW,
    PD_RSVD
  } pd_mode_t;

  typedef enum logic {
    WAIT_START,
    COUNT
  } pd_state_t;

  // Reserved mode behaves as rise-to-rise period.
  function automatic pd_mode_t pd_norm(input logic [1:0] m);
    pd_mode_t r;
    r = pd_mode_t'(m);
    if (r == PD_RSVD) r = PD_PERIOD;
    return r;
  endfunction

endpackage

// File: rtl/pd_edge_sync.sv
// Synchroniser chain plus history flop.
// Produces single-cycle rise/fall strobes of the synchronised input.
module pd_edge_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] sync_q;
  logic            hist_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], d_in};
      hist_q <= sync_q[SYNC-1];
    end
  end

  assign s    = sync_q[SYNC-1];
  assign rise = s & ~hist_q;
  assign fall = ~s & hist_q;

endmodule

// File: rtl/pd_measure.sv
// Pulse period / high / low time measurement with
// saturating counter and valid/ready result handshake.
module pd_measure
  import pd_pkg::*;
#(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enb,
  input  logic         clr,
  input  logic         pulse_in,
  input  logic [1:0]   mode,
  output logic [W-1:0] period,
  output logic         ovf,
  output logic         valid,
  input  logic         ready,
  output logic         missed
);

  localparam logic [W-1:0] MAX = '1;

  logic s_unused;
  logic rise;
  logic fall;

  pd_edge_sync #(.SYNC(SYNC)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .d_in (pulse_in),
    .s    (s_unused),
    .rise (rise),
    .fall (fall)
  );

  pd_state_t      state_q, state_d;
  pd_mode_t       mode_q, mode_d, mode_in;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   per_q, per_d;
  logic [W-1:0]   res;
  logic           ovf_q, ovf_d;
  logic           vld_q, vld_d;
  logic           mis_q, mis_d;
  logic           start_e, end_e, cap;

  always_comb begin
    mode_in = pd_norm(mode);
    start_e = (mode_in == PD_LOW) ? fall : rise;
    end_e   = (mode_q == PD_HIGH) ? fall : rise;
    // Final tick counts too, so P-cycle spacing yields P.
    res     = (cnt_q == MAX) ? MAX
            : cnt_q + {{(W-1){1'b0}}, enb};
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    mis_d   = mis_q;
    cap     = 1'b0;
    unique case (state_q)
      WAIT_START: begin
        if (start_e) begin
          cnt_d   = '0;
          mode_d  = mode_in;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (end_e) begin
          cap = 1'b1;
          if (mode_q == PD_PERIOD) cnt_d = '0;
          else state_d = WAIT_START;
        end else if (enb && cnt_q != MAX) begin
          cnt_d = cnt_q + W'(1);
        end
      end
    endcase
    if (cap) begin
      per_d = res;
      ovf_d = (res == MAX);
      vld_d = 1'b1;
      if (vld_q && !ready) mis_d = 1'b1;
    end else if (vld_q && ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= WAIT_START;
      mode_q  <= PD_PERIOD;
      cnt_q   <= '0;
      per_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  assign period = per_q;
  assign ovf    = ovf_q;
  assign valid  = vld_q;
  assign missed = mis_q;

endmodule

// File: tb/tb_pd_measure.sv
// Scoreboard bench for pd_measure: interval model from sampled
// pulse/enb history, monitor checks results on each handshake.
module tb_pd_measure;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, clr, enb, pulse_in, ready;
  logic [1:0]   mode;
  logic [W-1:0] period;
  logic         ovf, valid, missed;

  always #5 clk = ~clk;

  pd_measure #(.W(W), .SYNC(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .clr      (clr),
    .pulse_in (pulse_in),
    .mode     (mode),
    .period   (period),
    .ovf      (ovf),
    .valid    (valid),
    .ready    (ready),
    .missed   (missed)
  );

  typedef struct {
    int per;
    int ovf;
  } exp_t;

  int   total  = 0;
  int   passed = 0;
  exp_t q[$];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: pulse level and enb recorded per clock edge.
  bit ph[65536];
  bit eh[65536];
  int cyc      = 0;
  int rst_edge = 0;
  bit armed    = 0;
  bit counting = 0;
  int a_edge   = 0;
  int mm       = 0;
  bit ev       = 0;
  bit em       = 0;

  always @(posedge clk) begin : model
    int lvl, prv, ticks, res, nm;
    bit rise_e, fall_e, st, en, cap;
    exp_t e;
    cyc++;
    ph[cyc] = pulse_in;
    eh[cyc] = enb;
    if (rst || clr) begin
      armed    = 1;
      rst_edge = cyc;
      counting = 0;
      ev       = 0;
      em       = 0;
      q.delete();
    end else if (armed) begin
      lvl = (cyc - SYNC > rst_edge) ? int'(ph[cyc-SYNC]) : 0;
      prv = (cyc - SYNC - 1 > rst_edge) ? int'(ph[cyc-SYNC-1]) : 0;
      rise_e = (lvl == 1) && (prv == 0);
      fall_e = (lvl == 0) && (prv == 1);
      cap = 0;
      res = 0;
      if (counting) begin
        en = (mm == 1) ? fall_e : rise_e;
        if (en) begin
          ticks = 0;
          for (int i = a_edge + 1; i <= cyc; i++) ticks += int'(eh[i]);
          res = (ticks > MAXV) ? MAXV : ticks;
          cap = 1;
          if (mm == 0) a_edge = cyc;
          else counting = 0;
        end
      end else begin
        nm = (mode == 2'd3) ? 0 : int'(mode);
        st = (nm == 2) ? fall_e : rise_e;
        if (st) begin
          counting = 1;
          a_edge   = cyc;
          mm       = nm;
        end
      end
      if (cap) begin
        if (ev && !ready) begin
          void'(q.pop_back());
          em = 1;
        end
        e.per = res;
        e.ovf = (res == MAXV) ? 1 : 0;
        q.push_back(e);
        ev = 1;
      end else if (ev && ready) begin
        ev = 0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (armed) begin
      check("valid", int'(valid), int'(ev));
      check("missed", int'(missed), int'(em));
      if (valid && ready) begin
        check("pending", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("period", int'(period), e.per);
          check("ovf", int'(ovf), e.ovf);
        end
      end
    end
  end

  int emode = 0;
  int ecnt  = 0;
  bit rrand = 0;

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      ecnt++;
      case (emode)
        0:       enb = 1'b1;
        1:       enb = (ecnt % 4 == 0);
        2:       enb = 1'($urandom_range(0, 1));
        default: enb = 1'b0;
      endcase
      if (rrand) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    pulse_in = 1'b1;
    tick(hi);
    pulse_in = 1'b0;
    tick(lo);
  endtask

  task automatic clear();
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; enb = 1'b1; ready = 1'b1;
    mode = 2'd0; pulse_in = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_period", int'(period), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_missed", int'(missed), 0);

    mode = 2'd0;
    repeat (5) pulse(25, 25);
    clear();

    mode = 2'd1;
    repeat (3) pulse(20, 80);
    clear();
    mode = 2'd2;
    repeat (3) pulse(20, 80);
    clear();
    mode = 2'd1;
    pulse(20, 80);
    pulse_in = 1'b1;
    tick(5);
    mode = 2'd2;
    tick(15);
    pulse_in = 1'b0;
    tick(80);
    pulse(20, 80);
    clear();

    mode = 2'd0;
    repeat (3) pulse(150, 150);
    clear();

    emode = 1;
    repeat (3) pulse(50, 50);
    emode = 0;
    clear();

    mode = 2'd1;
    emode = 3;
    pulse(10, 40);
    emode = 0;
    clear();

    mode = 2'd0;
    ready = 1'b0;
    pulse(15, 15);
    pulse(20, 20);
    pulse(25, 25);
    pulse_in = 1'b1;
    tick(SYNC + 3);
    check("ovr_period", int'(period), 50);
    check("ovr_valid", int'(valid), 1);
    check("ovr_missed", int'(missed), 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(5);
    check("ovr_missed_hold", int'(missed), 1);
    ready = 1'b1;
    clear();

    pulse_in = 1'b0;
    tick(5);
    mode = 2'd0;
    pulse(30, 30);
    pulse_in = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    check("rstmid_valid", int'(valid), 0);
    check("rstmid_period", int'(period), 0);
    rst = 1'b0;
    pulse_in = 1'b0;
    tick(10);
    repeat (3) pulse(20, 20);

    pulse(30, 30);
    pulse_in = 1'b1;
    tick(10);
    clr = 1'b1;
    tick(2);
    check("clrmid_valid", int'(valid), 0);
    check("clrmid_period", int'(period), 0);
    clr = 1'b0;
    pulse_in = 1'b0;
    tick(10);
    repeat (3) pulse(20, 20);

    rrand = 1;
    emode = 2;
    repeat (30) begin
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) clear();
      pulse($urandom_range(1, 120), $urandom_range(1, 120));
    end
    rrand = 0;
    emode = 0;
    ready = 1'b1;
    tick(10);
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
